// File: rtl/calcu_pkg.sv
// -----------------------------------------------------------------------------
// calcu_pkg
// Shared definitions for the calculator sequencing controller:
//   - state_e   : controller state encoding (also exported on state_dbg)
//   - OP_*      : opcode values understood by the Calcu datapath
//   - OP_MAX    : highest legal opcode
//   - go_rejected() : operand/opcode validation applied when "go" is pressed
// -----------------------------------------------------------------------------
package calcu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_DONE  = 3'd2,
        ST_ERROR = 3'd3
    } state_e;

    localparam logic [3:0] OP_SUM    = 4'd0;
    localparam logic [3:0] OP_REST   = 4'd1;
    localparam logic [3:0] OP_MOD    = 4'd2;
    localparam logic [3:0] OP_MULT   = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_AND    = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_XOR    = 4'd7;
    localparam logic [3:0] OP_LSHIFT = 4'd8;
    localparam logic [3:0] OP_RSHIFT = 4'd9;
    localparam logic [3:0] OP_MAX    = OP_RSHIFT;

    // A go is refused for opcodes past the table, and for the two
    // operations that divide by B when B is zero.
    function automatic logic go_rejected(input logic [3:0] op, input logic b_zero);
        return (op > OP_MAX) || (((op == OP_MOD) || (op == OP_DIV)) && b_zero);
    endfunction

endpackage

// File: rtl/calcu_ctrl_btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Rising-edge detector for one already-synchronised push button.
// Ports:
//   clk_i   : system clock
//   rst_i   : synchronous reset, active-low
//   btn_i   : button level
//   pulse_o : one-cycle pulse on the first cycle btn_i is seen high
// The history register resets to 1 so a button held through reset is
// treated as "already pressed" and produces no pulse when reset releases.
// -----------------------------------------------------------------------------
module btn_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign pulse_o = btn_i & ~prev_q;

endmodule

// File: rtl/calcu_ctrl.sv
// -----------------------------------------------------------------------------
// calcu_ctrl
// Sequencing controller for the 4-bit Calcu datapath (ALU + result mux).
// Operands and opcode are loaded from a shared switch bus under button
// control; "go" validates and runs one operation, capturing the result and
// flags into holding registers.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   in_data             : switch bus (operand, or opcode in bits [3:0])
//   btn_a/b/op/chain/go : button levels (load A, load B, load opcode,
//                         load A from result, execute)
//   alu_a/alu_b/alu_sel : operand and opcode registers driven to Calcu
//   alu_salida/flags    : Calcu outputs, captured in EXEC
//   result/flags_q      : captured result and flags
//   result_valid        : holding registers contain a fresh result (DONE)
//   busy                : operation in flight (EXEC)
//   err                 : last go was rejected (ERROR)
//   op_count            : completed operations, wraps
//   state_dbg           : current state encoding
// Handshake: there is no back-pressure; a go pulse accepted in IDLE/DONE/
// ERROR yields result_valid exactly two edges later, and every button pulse
// arriving while busy is dropped rather than queued.
// -----------------------------------------------------------------------------
module calcu_ctrl
    import calcu_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_data,
    input  logic             btn_a,
    input  logic             btn_b,
    input  logic             btn_op,
    input  logic             btn_chain,
    input  logic             btn_go,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_sel,
    input  logic [N-1:0]     alu_salida,
    input  logic [3:0]       alu_flags,
    output logic [N-1:0]     result,
    output logic [3:0]       flags_q,
    output logic             result_valid,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] op_count,
    output logic [2:0]       state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------- buttons
    logic a_p, b_p, op_p, chain_p, go_p;

    btn_edge u_edge_a     (.clk_i(clk), .rst_i(rst), .btn_i(btn_a),     .pulse_o(a_p));
    btn_edge u_edge_b     (.clk_i(clk), .rst_i(rst), .btn_i(btn_b),     .pulse_o(b_p));
    btn_edge u_edge_op    (.clk_i(clk), .rst_i(rst), .btn_i(btn_op),    .pulse_o(op_p));
    btn_edge u_edge_chain (.clk_i(clk), .rst_i(rst), .btn_i(btn_chain), .pulse_o(chain_p));
    btn_edge u_edge_go    (.clk_i(clk), .rst_i(rst), .btn_i(btn_go),    .pulse_o(go_p));

    logic any_load_p;
    assign any_load_p = a_p | b_p | op_p | chain_p;

    // ------------------------------------------------------------- registers
    state_e           state_q, state_d;
    logic [N-1:0]     a_q, b_q, result_q;
    logic [3:0]       op_q, flg_q;
    logic [CNT_W-1:0] cnt_q;
    logic             reject;

    assign reject = go_rejected(op_q, (b_q == '0));

    // ------------------------------------------------------ FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------ FSM: next state
    // EXEC is a single fixed cycle. Every other state reacts to buttons the
    // same way; go wins over loads in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EXEC: state_d = ST_DONE;
            default: begin
                if (go_p) begin
                    state_d = reject ? ST_ERROR : ST_EXEC;
                end else if (any_load_p) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------ FSM: outputs
    // The status flags are exactly the state: valid only in DONE (any
    // go or load leaves DONE), err only in ERROR, busy only in EXEC.
    always_comb begin
        busy         = (state_q == ST_EXEC);
        result_valid = (state_q == ST_DONE);
        err          = (state_q == ST_ERROR);
        state_dbg    = state_q;
    end

    // ------------------------------------------------------ datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            flg_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == ST_EXEC) begin
            result_q <= alu_salida;
            flg_q    <= alu_flags;
            cnt_q    <= cnt_q + CNT_ONE;
        end else if (!go_p) begin
            // Chaining takes priority over a same-cycle switch load of A.
            if (chain_p) begin
                a_q <= result_q;
            end else if (a_p) begin
                a_q <= in_data;
            end
            if (b_p) begin
                b_q <= in_data;
            end
            if (op_p) begin
                op_q <= in_data[3:0];
            end
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_sel  = op_q;
    assign result   = result_q;
    assign flags_q  = flg_q;
    assign op_count = cnt_q;

endmodule

// File: tb/tb_calcu_ctrl.sv
module tb_calcu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in_data = '0;
    logic       btn_a = 1'b0, btn_b = 1'b0, btn_op = 1'b0, btn_chain = 1'b0, btn_go = 1'b0;
    logic [3:0] alu_a, alu_b, alu_sel, alu_salida, alu_flags;
    logic [3:0] result, flags_q;
    logic       result_valid, busy, err;
    logic [7:0] op_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model state (architectural view)
    logic [3:0] m_a, m_b, m_op, m_res, m_flags;
    logic [7:0] m_cnt;
    int         m_state;  // 0 idle, 1 exec, 2 done, 3 error

    calcu_ctrl #(.N(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data),
        .btn_a(btn_a), .btn_b(btn_b), .btn_op(btn_op),
        .btn_chain(btn_chain), .btn_go(btn_go),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_salida(alu_salida), .alu_flags(alu_flags),
        .result(result), .flags_q(flags_q), .result_valid(result_valid),
        .busy(busy), .err(err), .op_count(op_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Behavioural Calcu: plain integer arithmetic, result truncated to 4 bits.
    // Returns {carry, zero, negative, parity, result}.
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] sel);
        int r;
        int ai;
        int bi;
        logic [3:0] res;
        logic c;
        ai = int'(a);
        bi = int'(b);
        case (sel)
            4'd0: r = ai + bi;
            4'd1: r = ai - bi;
            4'd2: r = (bi != 0) ? ai % bi : 0;
            4'd3: r = ai * bi;
            4'd4: r = (bi != 0) ? ai / bi : 0;
            4'd5: r = ai & bi;
            4'd6: r = ai | bi;
            4'd7: r = ai ^ bi;
            4'd8: r = ai << bi;
            4'd9: r = ai >> bi;
            default: r = 0;
        endcase
        res = r[3:0];
        c = (r < 0) || (r > 15);
        return {c, (res == 4'd0), res[3], ^res, res};
    endfunction

    always_comb {alu_flags, alu_salida} = alu_ref(alu_a, alu_b, alu_sel);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0; m_cnt = 0; m_state = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_res"},   32'(result),       32'(m_res));
        chk({tag, "_flags"}, 32'(flags_q),      32'(m_flags));
        chk({tag, "_valid"}, 32'(result_valid), 32'(m_state == 2));
        chk({tag, "_err"},   32'(err),          32'(m_state == 3));
        chk({tag, "_busy"},  32'(busy),         32'(m_state == 1));
        chk({tag, "_cnt"},   32'(op_count),     32'(m_cnt));
        chk({tag, "_state"}, 32'(state_dbg),    32'(m_state));
        chk({tag, "_a"},     32'(alu_a),        32'(m_a));
        chk({tag, "_b"},     32'(alu_b),        32'(m_b));
        chk({tag, "_sel"},   32'(alu_sel),      32'(m_op));
    endtask

    // Press the selected load buttons together for one cycle, then release.
    task automatic load(input string tag, input logic [3:0] d,
                        input bit la, input bit lb, input bit lo, input bit lc);
        in_data = d;
        btn_a = la; btn_b = lb; btn_op = lo; btn_chain = lc;
        step();
        if (lc) m_a = m_res;
        else if (la) m_a = d;
        if (lb) m_b = d;
        if (lo) m_op = d;
        if (la || lb || lo || lc) m_state = 0;
        btn_a = 0; btn_b = 0; btn_op = 0; btn_chain = 0;
        step();
        check_all(tag);
    endtask

    task automatic set_abo(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op);
        load({tag, "_la"}, a, 1, 0, 0, 0);
        load({tag, "_lb"}, b, 0, 1, 0, 0);
        load({tag, "_lo"}, op, 0, 0, 1, 0);
    endtask

    task automatic do_go(input string tag);
        bit bad;
        bad = (m_op > 9) || (((m_op == 2) || (m_op == 4)) && (m_b == 0));
        btn_go = 1;
        step();
        btn_go = 0;
        if (bad) begin
            m_state = 3;
            check_all({tag, "_e0"});
            step();
        end else begin
            m_state = 1;
            check_all({tag, "_e0"});
            step();
            {m_flags, m_res} = alu_ref(m_a, m_b, m_op);
            m_cnt = m_cnt + 8'd1;
            m_state = 2;
        end
        check_all(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] d;
        model_reset();
        // Reset
        rst = 0;
        step(); step();
        rst = 1;
        step();
        check_all("reset");

        // Basic sum 3+5
        set_abo("t1", 4'd3, 4'd5, 4'd0);
        do_go("t1_go");
        chk("t1_result8", 32'(result), 32'd8);

        // 7+2 then chain, 9-3
        set_abo("t2", 4'd7, 4'd2, 4'd0);
        do_go("t2_go");
        load("t2_chain", 4'd0, 0, 0, 0, 1);
        load("t2_b3", 4'd3, 0, 1, 0, 0);
        load("t2_op1", 4'd1, 0, 0, 1, 0);
        chk("t2_chain_a9", 32'(alu_a), 32'd9);
        do_go("t2_sub");
        chk("t2_result6", 32'(result), 32'd6);

        // Divide by zero rejected, then recover with B=2
        set_abo("t3", 4'd6, 4'd0, 4'd4);
        do_go("t3_div0");
        load("t3_b2", 4'd2, 0, 1, 0, 0);
        do_go("t3_div");
        chk("t3_result3", 32'(result), 32'd3);

        // Illegal opcode
        load("t4_op12", 4'd12, 0, 0, 1, 0);
        do_go("t4_illegal");

        // go held high for 10 cycles: one execution
        set_abo("t5", 4'd4, 4'd3, 4'd3);
        btn_go = 1;
        for (int i = 0; i < 10; i++) step();
        btn_go = 0;
        step();
        {m_flags, m_res} = alu_ref(m_a, m_b, m_op);
        m_cnt = m_cnt + 8'd1;
        m_state = 2;
        check_all("t5_held_go");

        // btn_b pulse during EXEC ignored
        set_abo("t6", 4'd9, 4'd2, 4'd7);
        btn_go = 1;
        step();
        btn_go = 0;
        in_data = 4'hF;
        btn_b = 1;
        step();
        btn_b = 0;
        {m_flags, m_res} = alu_ref(m_a, m_b, m_op);
        m_cnt = m_cnt + 8'd1;
        m_state = 2;
        step();
        check_all("t6_b_in_exec");

        // a and chain together: chain wins
        load("t7_a_chain", 4'd1, 1, 0, 0, 1);

        // Random operations against the model
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: load("r_a", 4'($urandom_range(0, 15)), 1, 0, 0, 0);
                1: begin
                    d = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                    load("r_b", d, 0, 1, 0, 0);
                end
                2: load("r_op", 4'($urandom_range(0, 15)), 0, 0, 1, 0);
                3: load("r_chain", 4'($urandom_range(0, 15)), 0, 0, 0, 1);
                default: do_go("r_go");
            endcase
        end

        // go held through reset: no execution after release
        rst = 0;
        btn_go = 1;
        step(); step();
        model_reset();
        rst = 1;
        step(); step(); step();
        check_all("t8_go_thru_rst");
        btn_go = 0;
        step();
        check_all("t8_release");

        // Reset during EXEC aborts
        set_abo("t9", 4'd5, 4'd5, 4'd0);
        do_go("t9_first");
        btn_go = 1;
        step();
        btn_go = 0;
        chk("t9_in_exec", 32'(busy), 32'd1);
        rst = 0;
        step();
        model_reset();
        check_all("t9_rst_exec");
        rst = 1;
        step();
        check_all("t9_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
